apb_initiator: RTL and testbench
================================

APB_INITIATOR -- requirements
Module: apb_initiator

Interface
REQ-001 The module SHALL have parameter APB_ADDR_WIDTH, default 32, the width of the address on both ports.
REQ-002 The module SHALL have parameter APB_DATA_WIDTH, default 32, the width of the data on both ports.
REQ-003 The module SHALL have parameter TIMEOUT_CYCLES, default 255, the maximum number of ACCESS wait cycles; 0 disables the timeout.
REQ-004 clk_i  input  1  single clock; all logic is on its rising edge.
REQ-005 rst_i  input  1  reset, synchronous, active-high.
REQ-006 req_i  input  1  core request valid.
REQ-007 we_i  input  1  1 = write, 0 = read.
REQ-008 addr_i  input  APB_ADDR_WIDTH  request address.
REQ-009 wdata_i  input  APB_DATA_WIDTH  write data.
REQ-010 gnt_o  output  1  request accepted this cycle.
REQ-011 rvalid_o  output  1  one-cycle response pulse.
REQ-012 rdata_o  output  APB_DATA_WIDTH  read data, valid with rvalid_o.
REQ-013 err_o  output  1  slave error or timeout, valid with rvalid_o.
REQ-014 psel_o, penable_o, pwrite_o  output  1 each  APB control.
REQ-015 paddr_o  output  APB_ADDR_WIDTH  APB address.
REQ-016 pwdata_o  output  APB_DATA_WIDTH  APB write data.
REQ-017 prdata_i  input  APB_DATA_WIDTH  APB read data.
REQ-018 pready_i, pslverr_i  input  1 each  APB completion and error.

Function
REQ-019 The FSM SHALL have three states, IDLE, SETUP and ACCESS, and SHALL allow one outstanding transaction.
REQ-020 In IDLE, gnt_o SHALL equal req_i (combinational); when it is 1, the FSM SHALL register we_i, addr_i and wdata_i and go to SETUP.
REQ-021 SETUP SHALL drive psel_o=1 and penable_o=0, last exactly one cycle, then go to ACCESS.
REQ-022 ACCESS SHALL drive psel_o=1 and penable_o=1 and stay in ACCESS while pready_i=0 and the timeout has not expired.
REQ-023 pwrite_o, paddr_o and pwdata_o SHALL come from the registered request and SHALL stay constant from SETUP through the end of ACCESS.
REQ-024 In IDLE, pwrite_o, paddr_o and pwdata_o SHALL hold their last values.
REQ-025 When pready_i=1 in ACCESS, the FSM SHALL go to IDLE, and in the next cycle rvalid_o=1, err_o=pslverr_i, and rdata_o=prdata_i for a read or 0 for a write.
REQ-026 The wait counter SHALL reset to 0 on entry to ACCESS and increment on each ACCESS cycle with pready_i=0.
REQ-027 When the wait counter reaches TIMEOUT_CYCLES (TIMEOUT_CYCLES>0), the FSM SHALL go to IDLE, and the next cycle SHALL give rvalid_o=1, err_o=1 and rdata_o=0.
REQ-028 If pready_i=1 in the same cycle the timeout expires, pready_i SHALL take priority.
REQ-029 The wait counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1, and the counter SHALL saturate and not wrap.
REQ-030 gnt_o SHALL be 1 in the same cycle as rvalid_o when req_i=1, giving a minimum of 3 cycles per transaction.
REQ-031 gnt_o SHALL be 0 in SETUP and ACCESS.
REQ-032 pslverr_i and prdata_i SHALL be ignored outside ACCESS with pready_i=1.

Reset
REQ-033 While rst_i=1 at a clock edge, the state SHALL become IDLE and the counter SHALL become 0.
REQ-034 While rst_i=1 at a clock edge, psel_o, penable_o, pwrite_o, rvalid_o and err_o SHALL become 0.
REQ-035 While rst_i=1 at a clock edge, paddr_o, pwdata_o and rdata_o SHALL become 0.
REQ-036 Reset during SETUP or ACCESS SHALL abandon the transfer with no rvalid_o pulse, and psel_o SHALL be 0 in the cycle after the reset edge.
REQ-037 gnt_o SHALL be 0 while rst_i=1.

Structure
REQ-038 Package apb_initiator_pkg SHALL hold the state enum typedef (IDLE, SETUP, ACCESS) and the constant DEFAULT_TIMEOUT_CYCLES=255.
REQ-039 The wait counter SHALL be a sub-module apb_timeout_cnt with inputs clr, en and outputs expired, parameterised by TIMEOUT_CYCLES.

Verification
REQ-040 Read, zero wait: req with addr=0x1A10_0004, prdata=0xDEAD_BEEF, pready high in the first ACCESS -> psel high for 2 cycles, rvalid 1 cycle later with rdata=0xDEAD_BEEF and err=0.
REQ-041 Write, 3 wait states: addr=0x1A10_2000, wdata=0x1234_5678 -> paddr and pwdata stable for 5 cycles, rvalid with rdata=0 and err=0.
REQ-042 Slave error: pslverr=1 with pready -> rvalid with err=1.
REQ-043 Timeout: TIMEOUT_CYCLES=4 and pready held low -> ACCESS ends after 4 wait cycles, rvalid with err=1 and rdata=0; repeat with pready rising on the 4th cycle -> err=pslverr.
REQ-044 Back-to-back: req_i held high for 3 requests -> gnt coincides with each rvalid, 3-cycle spacing, and penable is never high while psel is low.
REQ-045 Reset mid-ACCESS: assert rst_i while in ACCESS -> next cycle psel=0, no rvalid, and a new request completes normally.

Source files
------------

// File: rtl/apb_initiator_pkg.sv
// apb_initiator_pkg
//   Shared types and constants for the APB initiator.
//   state_t                : transfer FSM encoding (IDLE, SETUP, ACCESS)
//   DEFAULT_TIMEOUT_CYCLES : default ACCESS wait limit
package apb_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 255;

endpackage

// File: rtl/apb_timeout_cnt.sv
// apb_timeout_cnt
//   Saturating wait-state counter for the APB ACCESS phase.
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset
//   clr     : clear counter to 0 (asserted on the cycle before ACCESS)
//   en      : count one wait cycle (ACCESS with pready low)
//   expired : the current wait cycle brings the count to TIMEOUT_CYCLES
//             (always 0 when TIMEOUT_CYCLES == 0)
module apb_timeout_cnt
    import apb_initiator_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int unsigned CW   = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] SAT  = CW'(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || clr)
            cnt <= '0;
        else if (en && cnt != SAT)
            cnt <= cnt + CW'(1);
    end

    // Expiry is flagged combinationally during the wait cycle that would
    // take the count to the limit, so the FSM leaves ACCESS after exactly
    // TIMEOUT_CYCLES wait cycles.
    generate
        if (TIMEOUT_CYCLES == 0) begin : g_no_timeout
            assign expired = 1'b0;
        end else begin : g_timeout
            assign expired = en && (cnt >= LAST);
        end
    endgenerate

endmodule

// File: rtl/apb_initiator.sv
// apb_initiator
//   Single-outstanding core-to-APB bridge. A granted request is registered,
//   driven through SETUP and ACCESS, and answered with a one-cycle response.
//   clk_i, rst_i                : clock, synchronous active-high reset
//   req_i, we_i, addr_i, wdata_i: core request
//   gnt_o                       : request accepted this cycle (IDLE only)
//   rvalid_o, rdata_o, err_o    : response pulse, read data, error/timeout
//   psel_o .. pwdata_o          : APB request side
//   prdata_i, pready_i, pslverr_i: APB completion side
module apb_initiator
    import apb_initiator_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic                      we_i,
    input  logic [APB_ADDR_WIDTH-1:0] addr_i,
    input  logic [APB_DATA_WIDTH-1:0] wdata_i,
    output logic                      gnt_o,
    output logic                      rvalid_o,
    output logic [APB_DATA_WIDTH-1:0] rdata_o,
    output logic                      err_o,
    output logic                      psel_o,
    output logic                      penable_o,
    output logic                      pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [APB_DATA_WIDTH-1:0] pwdata_o,
    input  logic [APB_DATA_WIDTH-1:0] prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    state_t state, next_state;
    logic   expired;
    logic   done;
    logic   timeout;

    assign done    = (state == ACCESS) && pready_i;
    assign timeout = (state == ACCESS) && !pready_i && expired;

    apb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout_cnt (
        .clk    (clk_i),
        .rst    (rst_i),
        .clr    (state == SETUP),
        .en     ((state == ACCESS) && !pready_i),
        .expired(expired)
    );

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i)
            state <= IDLE;
        else
            state <= next_state;
    end

    // Next-state logic; pready wins over a simultaneous timeout
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (req_i) next_state = SETUP;
            SETUP:   next_state = ACCESS;
            ACCESS:  if (done || timeout) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        psel_o    = (state != IDLE);
        penable_o = (state == ACCESS);
        gnt_o     = (state == IDLE) && req_i && !rst_i;
    end

    // Request capture and response registers. The APB request fields only
    // change on a grant, so they hold through SETUP/ACCESS and into IDLE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pwrite_o <= 1'b0;
            paddr_o  <= '0;
            pwdata_o <= '0;
            rvalid_o <= 1'b0;
            err_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            rvalid_o <= 1'b0;
            if (gnt_o) begin
                pwrite_o <= we_i;
                paddr_o  <= addr_i;
                pwdata_o <= wdata_i;
            end
            if (done) begin
                rvalid_o <= 1'b1;
                err_o    <= pslverr_i;
                rdata_o  <= pwrite_o ? '0 : prdata_i;
            end else if (timeout) begin
                rvalid_o <= 1'b1;
                err_o    <= 1'b1;
                rdata_o  <= '0;
            end
        end
    end

endmodule

// File: tb/tb_apb_initiator.sv
// tb_apb_initiator
//   Directed bench for apb_initiator with TIMEOUT_CYCLES = 4. Inputs change
//   2 time units after the rising edge; outputs are checked 1 unit later.
module tb_apb_initiator;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req;
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic          gnt;
    logic          rvalid;
    logic [DW-1:0] rdata;
    logic          err;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata;
    logic          pready;
    logic          pslverr;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    apb_initiator #(
        .APB_ADDR_WIDTH(AW),
        .APB_DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(4)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .req_i    (req),
        .we_i     (we),
        .addr_i   (addr),
        .wdata_i  (wdata),
        .gnt_o    (gnt),
        .rvalid_o (rvalid),
        .rdata_o  (rdata),
        .err_o    (err),
        .psel_o   (psel),
        .penable_o(penable),
        .pwrite_o (pwrite),
        .paddr_o  (paddr),
        .pwdata_o (pwdata),
        .prdata_i (prdata),
        .pready_i (pready),
        .pslverr_i(pslverr)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Let combinational outputs settle after an input change
    task automatic settle();
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req = 1'b1; we = 1'b1; addr = 32'hFFFF_FFFF; wdata = 32'hFFFF_FFFF;
        prdata = 32'h0; pready = 1'b1; pslverr = 1'b1;

        // ---------------- reset ----------------
        tick(); tick(); settle();
        chk("gnt_in_reset", gnt, 0);
        chk("rst_psel", psel, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_rvalid", rvalid, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        req = 1'b0; pready = 1'b0; pslverr = 1'b0;
        tick(); rst = 1'b0; settle();

        // ---------------- read, zero wait ----------------
        req = 1'b1; we = 1'b0; addr = 32'h1A10_0004; settle();
        chk("rd0_gnt_idle", gnt, 1);
        tick(); req = 1'b1; settle();           // SETUP, req still high
        chk("rd0_gnt_setup", gnt, 0);
        chk("rd0_setup_psel", psel, 1);
        chk("rd0_setup_penable", penable, 0);
        chk("rd0_paddr", paddr, 32'h1A10_0004);
        chk("rd0_pwrite", pwrite, 0);
        req = 1'b0;
        tick(); pready = 1'b1; prdata = 32'hDEAD_BEEF; settle();   // ACCESS
        chk("rd0_access_psel", psel, 1);
        chk("rd0_access_penable", penable, 1);
        chk("rd0_access_gnt", gnt, 0);
        chk("rd0_access_rvalid", rvalid, 0);
        tick(); pready = 1'b0; prdata = 32'h0; settle();            // IDLE + response
        chk("rd0_psel_off", psel, 0);
        chk("rd0_rvalid", rvalid, 1);
        chk("rd0_rdata", rdata, 32'hDEAD_BEEF);
        chk("rd0_err", err, 0);
        tick(); settle();
        chk("rd0_rvalid_pulse", rvalid, 0);

        // ---------------- write, 3 wait states ----------------
        req = 1'b1; we = 1'b1; addr = 32'h1A10_2000; wdata = 32'h1234_5678;
        prdata = 32'hFFFF_FFFF; settle();
        chk("wr3_gnt", gnt, 1);
        tick(); req = 1'b0; addr = 32'h0; wdata = 32'h0; settle();
        for (int c = 0; c < 5; c++) begin        // SETUP + 4 ACCESS cycles
            if (c == 4) pready = 1'b1;
            settle();
            chk("wr3_paddr_stable", paddr, 32'h1A10_2000);
            chk("wr3_pwdata_stable", pwdata, 32'h1234_5678);
            chk("wr3_pwrite", pwrite, 1);
            chk("wr3_penable", penable, (c != 0));
            chk("wr3_rvalid_early", rvalid, 0);
            tick();
        end
        pready = 1'b0; settle();
        chk("wr3_rvalid", rvalid, 1);
        chk("wr3_rdata_zero", rdata, 0);
        chk("wr3_err", err, 0);
        chk("wr3_paddr_hold_idle", paddr, 32'h1A10_2000);
        chk("wr3_pwdata_hold_idle", pwdata, 32'h1234_5678);

        // ---------------- slave error ----------------
        tick(); req = 1'b1; we = 1'b0; addr = 32'h1A10_0010; settle();
        tick(); req = 1'b0; settle();
        tick(); pready = 1'b1; pslverr = 1'b1; prdata = 32'h0000_0055; settle();
        tick(); pready = 1'b0; pslverr = 1'b0; settle();
        chk("slverr_rvalid", rvalid, 1);
        chk("slverr_err", err, 1);
        chk("slverr_rdata", rdata, 32'h0000_0055);

        // ---------------- timeout, pready never comes ----------------
        tick(); req = 1'b1; we = 1'b0; addr = 32'h1A10_0020; prdata = 32'h7777_7777; settle();
        tick(); req = 1'b0; settle();
        for (int c = 0; c < 4; c++) begin
            tick(); settle();
            chk("to_in_access", penable, 1);
            chk("to_no_rvalid", rvalid, 0);
        end
        tick(); settle();
        chk("to_psel_off", psel, 0);
        chk("to_rvalid", rvalid, 1);
        chk("to_err", err, 1);
        chk("to_rdata_zero", rdata, 0);

        // ---------------- pready on the expiring cycle wins ----------------
        tick(); req = 1'b1; we = 1'b0; addr = 32'h1A10_0024; settle();
        tick(); req = 1'b0; settle();
        for (int c = 0; c < 4; c++) begin
            tick();
            if (c == 3) begin pready = 1'b1; prdata = 32'h0000_A5A5; end
            settle();
        end
        tick(); pready = 1'b0; prdata = 32'h0; settle();
        chk("prio_rvalid", rvalid, 1);
        chk("prio_err", err, 0);
        chk("prio_rdata", rdata, 32'h0000_A5A5);

        // ---------------- back-to-back writes ----------------
        tick(); req = 1'b1; we = 1'b1; pready = 1'b1; wdata = 32'hCAFE_0000;
        for (int i = 0; i < 9; i++) begin
            addr = 32'h1A10_3000 + 32'(4 * (i / 3));
            settle();
            chk("b2b_gnt", gnt, (i % 3) == 0);
            chk("b2b_rvalid", rvalid, ((i % 3) == 0) && (i > 0));
            chk("b2b_psel", psel, (i % 3) != 0);
            chk("b2b_penable_no_psel", penable && !psel, 0);
            if ((i % 3) == 1) chk("b2b_paddr", paddr, 32'h1A10_3000 + 32'(4 * (i / 3)));
            tick();
        end
        req = 1'b0; settle();
        chk("b2b_last_rvalid", rvalid, 1);
        chk("b2b_last_gnt", gnt, 0);
        pready = 1'b0;

        // ---------------- reset during ACCESS ----------------
        tick(); req = 1'b1; we = 1'b0; addr = 32'h1A10_4000; settle();
        tick(); req = 1'b0; settle();
        tick(); settle();
        chk("rst_mid_in_access", penable, 1);
        rst = 1'b1;
        tick(); rst = 1'b0; settle();
        chk("rst_mid_psel", psel, 0);
        chk("rst_mid_rvalid", rvalid, 0);
        chk("rst_mid_paddr", paddr, 0);
        tick(); settle();
        chk("rst_mid_no_pulse", rvalid, 0);
        req = 1'b1; addr = 32'h1A10_4004; settle();
        chk("rst_mid_new_gnt", gnt, 1);
        tick(); req = 1'b0; settle();
        tick(); pready = 1'b1; prdata = 32'h0BAD_F00D; settle();
        tick(); pready = 1'b0; prdata = 32'h0; settle();
        chk("rst_mid_new_rvalid", rvalid, 1);
        chk("rst_mid_new_rdata", rdata, 32'h0BAD_F00D);
        chk("rst_mid_new_err", err, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
